// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the instruction memory loader
// Purpose: loader FSM state type, bytes per word and the memory image fill word.
// Ports: none (package).
package arm_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int WORD_BYTES = 4;

  // Fill word used for unused locations of the memory image.
  localparam logic [31:0] NOP_WORD = 32'hE000_0000;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream input and word write port of the loader
// Purpose: groups the incoming byte-stream handshake and the instruction memory write port.
// Signals:
//   in_valid/in_data/in_last : byte stream from the image source
//   in_ready                 : loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data    : one-cycle word write towards instruction memory
// Modports: master = image source / memory side, slave = loader.
interface instr_mem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs accepted bytes into a big-endian 32-bit word
// Purpose: byte-index counter plus insert register; byte k lands in bits [31-8k -: 8].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart packing at byte 0 with an empty word
//   load       : a byte is accepted this cycle
//   byte_in    : the accepted byte
//   word_full  : the byte being loaded completes the word
//   word_next  : packing register with byte_in inserted at the current index
module word_packer
  import arm_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word_next
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      word_q;

  // word_next already contains the incoming byte so the completed word can be
  // registered for the write on the same edge as the last byte is accepted.
  always_comb begin
    word_next = word_q;
    word_next[8*(WORD_BYTES-1-int'(idx_q)) +: 8] = byte_in;
  end

  assign word_full = load && (idx_q == IDX_W'(WORD_BYTES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      word_q <= word_next;
      idx_q  <= word_full ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams a program image into instruction memory
// Purpose: accepts a byte stream, packs big-endian words, writes them from BASE_ADDR upward
//   and holds the CPU until the whole image is written.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a new load (honoured in IDLE, DONE, ERR)
//   bus         : byte stream in / word write out (instr_mem_loader_if.slave)
//   cpu_hold    : 0 only once the image is complete
//   done, error : load complete / load aborted levels
//   word_count  : words written in the current load
module instr_mem_loader
  import arm_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    word_count
);

  localparam logic [31:0] BASE_W = BASE_ADDR[31:0];
  localparam logic [31:0] MEM_W  = MEM_BYTES[31:0];

  loader_state_t state_q;
  logic          in_ready_q;
  logic          wr_en_q;
  logic [31:0]   wr_addr_q;
  logic [31:0]   wr_data_q;
  logic          last_q;

  logic          xfer;
  logic          start_ok;
  logic          word_full;
  logic [31:0]   word_next;
  logic [31:0]   cur_addr;

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  assign xfer     = bus.in_valid && in_ready_q;
  assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign cur_addr = BASE_W + (32'(word_count) << 2);

  word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .load      (xfer),
    .byte_in   (bus.in_data),
    .word_full (word_full),
    .word_next (word_next)
  );

  // in_ready is registered alongside the state, so it is high exactly in RECV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_W;
      wr_data_q  <= '0;
      last_q     <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_ok) begin
            state_q    <= RECV;
            in_ready_q <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            last_q     <= 1'b0;
          end
        end
        RECV: begin
          if (xfer) begin
            if (word_full) begin
              in_ready_q <= 1'b0;
              if (cur_addr >= MEM_W) begin
                // Word would fall outside the memory: abort without writing.
                state_q <= ERR;
                error   <= 1'b1;
              end else begin
                state_q   <= WRITE;
                wr_en_q   <= 1'b1;
                wr_addr_q <= cur_addr;
                wr_data_q <= word_next;
                last_q    <= bus.in_last;
              end
            end else if (bus.in_last) begin
              // Image ended mid-word; the partial word is dropped.
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + CNT_W'(1);
          if (last_q) begin
            state_q  <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state_q    <= RECV;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  logic clk;
  logic rst_n;
  logic start0;
  logic start1;

  logic       cpu_hold0, done0, error0;
  logic       cpu_hold1, done1, error1;
  logic [6:0] wc0, wc1;

  int errors = 0;
  int checks = 0;
  int rdy_viol = 0;

  logic [63:0] wq0[$];
  logic [63:0] wq1[$];
  logic [7:0]  img[$];

  instr_mem_loader_if if0 ();
  instr_mem_loader_if if1 ();

  instr_mem_loader #(.MEM_BYTES(256), .BASE_ADDR(0), .CNT_W(7)) u0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start0),
    .bus        (if0),
    .cpu_hold   (cpu_hold0),
    .done       (done0),
    .error      (error0),
    .word_count (wc0)
  );

  instr_mem_loader #(.MEM_BYTES(256), .BASE_ADDR(248), .CNT_W(7)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .bus        (if1),
    .cpu_hold   (cpu_hold1),
    .done       (done1),
    .error      (error1),
    .word_count (wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (if0.wr_en === 1'b1) begin
      wq0.push_back({if0.wr_addr, if0.wr_data});
      if (if0.in_ready !== 1'b0) rdy_viol++;
    end
    if (if1.wr_en === 1'b1) begin
      wq1.push_back({if1.wr_addr, if1.wr_data});
      if (if1.in_ready !== 1'b0) rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte, waits for the transfer edge, returns at a negedge.
  task automatic send(input int sel, input logic [7:0] d, input logic l, input int gap);
    int n = 0;
    if (sel == 0) begin
      if0.in_valid = 1'b1; if0.in_data = d; if0.in_last = l;
    end else begin
      if1.in_valid = 1'b1; if1.in_data = d; if1.in_last = l;
    end
    while ((((sel == 0) ? if0.in_ready : if1.in_ready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL xfer_timeout: observed in_ready stuck low for %0d cycles expected 1", n);
    end
    @(negedge clk);
    if (sel == 0) begin
      if0.in_valid = 1'b0; if0.in_last = 1'b0;
    end else begin
      if1.in_valid = 1'b0; if1.in_last = 1'b0;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_img(input int sel, input int gap, input bit with_last);
    for (int i = 0; i < img.size(); i++)
      send(sel, img[i], with_last && (i == img.size() - 1), gap);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.in_last = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.in_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 64'(if0.in_ready), 64'd0);
    chk("rst_wr_en", 64'(if0.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(if0.wr_addr), 64'd0);
    chk("rst_wr_addr_base248", 64'(if1.wr_addr), 64'd248);
    chk("rst_wr_data", 64'(if0.wr_data), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold0), 64'd1);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_error", 64'(error0), 64'd0);
    chk("rst_word_count", 64'(wc0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: start together with in_valid in IDLE (0xFF must not be taken), then 8 bytes
    if0.in_valid = 1'b1; if0.in_data = 8'hFF;
    pulse_start(0);
    if0.in_valid = 1'b0;
    chk("t1_ready_after_start", 64'(if0.in_ready), 64'd1);
    img = '{8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
    send_img(0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t1_nwrites", 64'(wq0.size()), 64'd2);
    chk("t1_write0", wq0[0], {32'h0000_0000, 32'hE3A0_0014});
    chk("t1_write1", wq0[1], {32'h0000_0004, 32'hE3A0_1A01});
    chk("t1_done", 64'(done0), 64'd1);
    chk("t1_cpu_hold", 64'(cpu_hold0), 64'd0);
    chk("t1_word_count", 64'(wc0), 64'd2);
    chk("t1_hold_addr_data", {if0.wr_addr, if0.wr_data}, {32'h0000_0004, 32'hE3A0_1A01});
    chk("t1_in_ready_done", 64'(if0.in_ready), 64'd0);
    wq0.delete();

    // Test 2: same image, valid toggling, plus an ignored start mid-load
    pulse_start(0);
    chk("t2_done_cleared", 64'(done0), 64'd0);
    chk("t2_wc_cleared", 64'(wc0), 64'd0);
    send(0, 8'hE3, 1'b0, 1);
    send(0, 8'hA0, 1'b0, 1);
    pulse_start(0);
    send(0, 8'h00, 1'b0, 1);
    send(0, 8'h14, 1'b0, 1);
    send(0, 8'hE3, 1'b0, 1);
    send(0, 8'hA0, 1'b0, 1);
    send(0, 8'h1A, 1'b0, 1);
    send(0, 8'h01, 1'b1, 1);
    repeat (3) @(negedge clk);
    chk("t2_nwrites", 64'(wq0.size()), 64'd2);
    chk("t2_write0", wq0[0], {32'h0000_0000, 32'hE3A0_0014});
    chk("t2_write1", wq0[1], {32'h0000_0004, 32'hE3A0_1A01});
    chk("t2_ready_low_in_write", 64'(rdy_viol), 64'd0);
    chk("t2_done", 64'(done0), 64'd1);
    wq0.delete();

    // Test 3: in_last on the 6th byte
    pulse_start(0);
    img = '{8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0};
    send_img(0, 0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_nwrites", 64'(wq0.size()), 64'd1);
    chk("t3_write0", wq0[0], {32'h0000_0000, 32'hE3A0_0014});
    chk("t3_error", 64'(error0), 64'd1);
    chk("t3_cpu_hold", 64'(cpu_hold0), 64'd1);
    chk("t3_done", 64'(done0), 64'd0);
    chk("t3_in_ready", 64'(if0.in_ready), 64'd0);
    chk("t3_word_count", 64'(wc0), 64'd1);
    wq0.delete();

    // Test 4: BASE_ADDR=248, third word overflows the memory
    pulse_start(1);
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_img(1, 0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t4_nwrites", 64'(wq1.size()), 64'd2);
    chk("t4_write0", wq1[0], {32'd248, 32'h0102_0304});
    chk("t4_write1", wq1[1], {32'd252, 32'h0506_0708});
    chk("t4_error", 64'(error1), 64'd1);
    chk("t4_cpu_hold", 64'(cpu_hold1), 64'd1);
    chk("t4_word_count", 64'(wc1), 64'd2);

    // Test 5: reset after two bytes of word 1, then a clean 4-byte load
    pulse_start(0);
    send(0, 8'h12, 1'b0, 0);
    send(0, 8'h34, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_cpu_hold", 64'(cpu_hold0), 64'd1);
    chk("t5_rst_in_ready", 64'(if0.in_ready), 64'd0);
    chk("t5_rst_wc", 64'(wc0), 64'd0);
    chk("t5_rst_error", 64'(error0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(0);
    img = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_img(0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_nwrites", 64'(wq0.size()), 64'd1);
    chk("t5_write0", wq0[0], {32'h0000_0000, 32'h5566_7788});
    chk("t5_done", 64'(done0), 64'd1);
    wq0.delete();

    // Test 6: reload from DONE
    pulse_start(0);
    chk("t6_done_cleared", 64'(done0), 64'd0);
    chk("t6_cpu_hold_set", 64'(cpu_hold0), 64'd1);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_img(0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_word_count", 64'(wc0), 64'd1);
    chk("t6_nwrites", 64'(wq0.size()), 64'd1);
    chk("t6_write0", wq0[0], {32'h0000_0000, 32'hAABB_CCDD});
    chk("t6_done", 64'(done0), 64'd1);
    chk("t6_cpu_hold", 64'(cpu_hold0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
